// File: rtl/sw_pkg.sv
// sw_pkg: shared defaults and collector state encoding
package sw_pkg;
  localparam int SCORE_W_DEF = 12;
  localparam int CNT_W_DEF = 10;
  typedef enum logic [1:0] {IDLE, RECV, HOLD} state_t;
endpackage

// File: rtl/max.sv
// max: two-input unsigned maximum
module max #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = (a > b) ? a : b;
endmodule

// File: rtl/sw_collector.sv
// sw_collector: reduces a systolic-chain burst to best score, length and position (SW_COLLECTOR_POS_EN enables end_pos)
module sw_collector
  import sw_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  input  logic [1:0]         t_in,
  input  logic [SCORE_W-1:0] max_in,
  input  logic [SCORE_W-1:0] v_in,
  input  logic               score_ready,
  output logic               score_valid,
  output logic [SCORE_W-1:0] score_out,
  output logic [CNT_W-1:0]   len_out,
  output logic [CNT_W-1:0]   end_pos,
  output logic               overrun,
  output logic               len_sat
);
  state_t state, next;
  logic [SCORE_W-1:0] cand, best;
  logic [CNT_W-1:0] cnt;
  logic hs, sat, load, step, done, better, unused_t;
  max #(.W(SCORE_W)) u_max (.a(max_in), .b(v_in), .y(cand));
  assign unused_t = ^t_in;
  assign hs = score_valid && score_ready;
  assign sat = &cnt;
  assign better = cand > best;
  assign load = valid_in && (state == IDLE || (state == HOLD && hs));
  assign step = valid_in && state == RECV;
  assign done = !valid_in && state == RECV;
  always_comb begin
    next = state;
    next = state == IDLE ? (valid_in ? RECV : IDLE) :
           state == RECV ? (valid_in ? RECV : HOLD) :
           hs ? (valid_in ? RECV : IDLE) : HOLD;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best <= '0;
      cnt <= '0;
      score_valid <= 1'b0;
      score_out <= '0;
      len_out <= '0;
      overrun <= 1'b0;
      len_sat <= 1'b0;
    end else begin
      if (load) begin
        best <= cand;
        cnt <= CNT_W'(1);
      end else if (step) begin
        if (better) best <= cand;
        if (sat) len_sat <= 1'b1;
        else cnt <= cnt + 1'b1;
      end
      if (done) begin
        score_valid <= 1'b1;
        score_out <= best;
        len_out <= cnt;
      end else if (hs) score_valid <= 1'b0;
      if (state == HOLD && !hs && valid_in) overrun <= 1'b1;
    end
  end
`ifdef SW_COLLECTOR_POS_EN
  logic [CNT_W-1:0] pos;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
      end_pos <= '0;
    end else begin
      if (load) pos <= '0;
      else if (step && !sat && better) pos <= cnt;
      if (done) end_pos <= pos;
    end
  end
`else
  assign end_pos = '0;
`endif
endmodule

// File: doc/sw_collector.md
SW_COLLECTOR -- requirements
Module: sw_collector

Interface
REQ-001 SHALL have parameter SCORE_W, default 12: width of all score buses.
REQ-002 SHALL have parameter CNT_W, default 10: width of the length and position counters.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port valid_in, input, 1: valid from the last PE of the systolic chain.
REQ-006 SHALL have port t_in, input, 2: target base from the last PE (pass-through only, unused in scoring).
REQ-007 SHALL have port max_in, input, SCORE_W: running maximum from the last PE.
REQ-008 SHALL have port v_in, input, SCORE_W: cell score from the last PE.
REQ-009 SHALL have port score_ready, input, 1: result consumer ready.
REQ-010 SHALL have port score_valid, output, 1: result available.
REQ-011 SHALL have port score_out, output, SCORE_W: best alignment score of the burst.
REQ-012 SHALL have port len_out, output, CNT_W: number of valid cycles in the burst.
REQ-013 SHALL have port end_pos, output, CNT_W: zero-based burst index at which score_out was first reached.
REQ-014 SHALL have port overrun, output, 1: sticky flag, burst arrived while a result was pending.
REQ-015 SHALL have port len_sat, output, 1: sticky flag, length counter saturated.

Function
REQ-016 SHALL implement states IDLE, RECV, HOLD; all compares unsigned, SCORE_W bits.
REQ-017 SHALL compute per-cycle candidate = max(max_in, v_in).
REQ-018 IDLE with valid_in=1 SHALL go to RECV and load best=candidate, cnt=1, pos=0.
REQ-019 RECV with valid_in=1 SHALL set cnt=cnt+1; if candidate > best (strict), best=candidate and pos=cnt (pre-increment value); ties keep the earlier pos.
REQ-020 cnt SHALL saturate at 2^CNT_W-1; a valid cycle arriving at saturation SHALL set len_sat and leave pos unchanged.
REQ-021 RECV with valid_in=0 SHALL go to HOLD; score_valid SHALL rise on the same edge (latency 1 cycle after the first low valid_in), with score_out=best, len_out=cnt, end_pos=pos registered.
REQ-022 HOLD SHALL keep score_valid and all result outputs stable until score_valid && score_ready is sampled.
REQ-023 HOLD with handshake and valid_in=0 SHALL go to IDLE and clear score_valid.
REQ-024 HOLD with handshake and valid_in=1 in the same cycle SHALL go directly to RECV and load the new burst per REQ-018, with no lost cycle.
REQ-025 HOLD with valid_in=1 and no handshake SHALL discard the sample, set overrun, and leave the result unchanged.
REQ-026 t_in SHALL not affect any output.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE and all outputs, best, cnt, pos, overrun, len_sat to 0.
REQ-028 Reset during RECV or HOLD SHALL discard the partial burst and any pending result; no score_valid follows.

Configuration
REQ-029 Macro SW_COLLECTOR_POS_EN defined: pos tracking per REQ-019 and REQ-013 is compiled in.
REQ-030 Macro SW_COLLECTOR_POS_EN undefined: pos register and compare logic are omitted and end_pos is tied to 0; all other behaviour is unchanged.

Structure
REQ-031 Package sw_pkg SHALL hold SCORE_W and CNT_W defaults, and the state enumeration (IDLE, RECV, HOLD).
REQ-032 The candidate computation SHALL instantiate the existing two-input max comparator module max; no other sub-module.

Verification
REQ-033 Burst of 4 with (max_in,v_in) = (3,5),(5,9),(9,9),(9,4), ready=1 -> score_valid 1 cycle after the burst ends, score_out=9, len_out=4, end_pos=1.
REQ-034 Same burst with score_ready=0 for 5 cycles -> outputs held stable for 5 cycles, then cleared one cycle after ready=1.
REQ-035 Result pending, ready=0, 2-cycle burst arrives -> overrun=1, score_out unchanged; 2nd burst lost.
REQ-036 Handshake in the same cycle as a new burst (v_in=7) -> state RECV, best=7, cnt=1; next result reports that burst only.
REQ-037 CNT_W=3, burst of 10 -> len_out=7, len_sat=1; without SW_COLLECTOR_POS_EN, end_pos=0.
REQ-038 rst_n low mid-burst after 3 samples -> all outputs 0 immediately; no score_valid until a new burst completes.
